// File: rtl/tt_btn_conditioner.sv
// rtl/tt_btn_conditioner.sv - button synchroniser, debouncer, edge detector and step generator
// Auto-repeat (WAIT/REPEATING states and rcnt) exists only when BTN_REPEAT_EN is defined.
module tt_btn_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic enable,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse,
  output logic held
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);

  // An illegal parameter set leaves the step generator permanently inert.
  localparam bit CFG_OK = (SYNC_STAGES >= 2) && (DEBOUNCE_CYCLES >= 1) &&
                          (REPEAT_DELAY >= 2) && (REPEAT_PERIOD >= 2);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic                   level_q, level_d;
  logic                   press_q, release_q, step_q;
  logic                   rise, fall, run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    level_d = level_q;
    dcnt_d  = dcnt_q;
    if (s == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_MAX) begin
      level_d = s;
      dcnt_d  = '0;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;
  assign run  = enable && CFG_OK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= 1'b0;
      dcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      dcnt_q    <= dcnt_d;
      press_q   <= rise;
      release_q <= fall;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REPEATING
  } state_e;

  state_e        state_q;
  logic [RW-1:0] rcnt_q;
  logic          held_q;

  // A falling level or a dropped enable always wins over a repeat terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
      step_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (!run || fall) begin
        state_q <= ST_IDLE;
        rcnt_q  <= '0;
        held_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise) begin
              state_q <= ST_WAIT;
              rcnt_q  <= '0;
              step_q  <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (rcnt_q == DELAY_MAX) begin
              state_q <= ST_REPEATING;
              rcnt_q  <= '0;
              step_q  <= 1'b1;
              held_q  <= 1'b1;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          ST_REPEATING: begin
            if (rcnt_q == PERIOD_MAX) begin
              rcnt_q <= '0;
              step_q <= 1'b1;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
            held_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign held = held_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= rise & run;
    end
  end

  assign held = 1'b0;
`endif

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign step_pulse    = step_q;

endmodule

// File: tb/tb_tt_btn_conditioner.sv
// tb/tb_tt_btn_conditioner.sv - directed-vector bench for tt_btn_conditioner
module tb_tt_btn_conditioner;

`ifdef BTN_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic enable;
  logic level, press_pulse, release_pulse, step_pulse, held;

  int n_checks = 0;
  int n_pass   = 0;

  tt_btn_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .enable       (enable),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .step_pulse   (step_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    enable  = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   level,         1'b0);
    check({tag, "_press"},   press_pulse,   1'b0);
    check({tag, "_release"}, release_pulse, 1'b0);
    check({tag, "_step"},    step_pulse,    1'b0);
    check({tag, "_held"},    held,          1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    enable  = 1'b1;
    #1;
    check_all_zero("reset");

    // Clean press, auto-repeat, release on a repeat terminal count (edge 47)
    do_reset();
    for (int e = 1; e <= 50; e++) begin
      btn_raw = (e <= 41);
      tick();
      check("s1_level",   level,         (e >= 6) && (e < 47));
      check("s1_press",   press_pulse,   e == 6);
      check("s1_release", release_pulse, e == 47);
      check("s1_step",    step_pulse,
            (e == 6) || (RPT && (e >= 14) && (e < 47) && ((e - 14) % 3 == 0)));
      check("s1_held",    held,          RPT && (e >= 14) && (e < 47));
    end

    // Three-sample glitch is rejected
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      btn_raw = (e <= 3);
      tick();
      check("s2_level", level,       1'b0);
      check("s2_press", press_pulse, 1'b0);
      check("s2_step",  step_pulse,  1'b0);
    end
    check("s2_dcnt_zero", dut.dcnt_q == '0, 1'b1);

    // Press while disabled, enable raised while held, release
    do_reset();
    for (int e = 1; e <= 50; e++) begin
      enable  = (e > 20);
      btn_raw = (e <= 40);
      tick();
      check("s4_level",   level,         (e >= 6) && (e < 46));
      check("s4_press",   press_pulse,   e == 6);
      check("s4_release", release_pulse, e == 46);
      check("s4_step",    step_pulse,    1'b0);
      check("s4_held",    held,          1'b0);
    end
    // Fresh press with enable; enable dropped after edge 15
    for (int e = 1; e <= 20; e++) begin
      enable  = (e <= 15);
      btn_raw = 1'b1;
      tick();
      check("s4b_press", press_pulse, e == 6);
      check("s4b_step",  step_pulse,  (e == 6) || (RPT && (e == 14)));
      check("s4b_held",  held,        RPT && ((e == 14) || (e == 15)));
    end

    // Reset in the middle of repeating, button kept held
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      btn_raw = 1'b1;
      tick();
      check("s5_step", step_pulse, (e == 6) || (RPT && (e >= 14) && ((e - 14) % 3 == 0)));
    end
    check("s5_held_pre", held,  RPT);
    check("s5_level_pre", level, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all_zero("s5_async");
    repeat (2) tick();
    check_all_zero("s5_inreset");
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("s5_post_press", press_pulse, k == 6);
      check("s5_post_step",  step_pulse,  k == 6);
      check("s5_post_level", level,       k >= 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
